int_issue_queue: RTL and testbench

INT_ISSUE_QUEUE -- requirements
Module: int_issue_queue

---
 rtl/int_issue_queue.sv | 178 +++++++++++++++++
 tb/tb_int_issue_queue.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_issue_queue.sv
// Integer issue queue: age-ordered entries, CDB wakeup, oldest-ready select, compaction on issue.
// Optional macro ISSUEQ_CDB_BYPASS_EN: a dispatched operand also captures a same-cycle CDB match.
module int_issue_queue #(
   parameter int DEPTH = 4
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Dispatch_en_Int,
   input  logic [3:0]  Dispatch_Opcode,
   input  logic [4:0]  Dispatch_Shfamt,
   input  logic [31:0] Dispatch_Imm_LS,
   input  logic        Dispatch_Type_I,
   input  logic [5:0]  Dispatch_RsTag,
   input  logic [5:0]  Dispatch_RtTag,
   input  logic [31:0] Dispatch_RsData,
   input  logic [31:0] Dispatch_RtData,
   input  logic        Dispatch_RsRdy,
   input  logic        Dispatch_RtRdy,
   input  logic [5:0]  Dispatch_RdTag,
   output logic        IssueQ_Full,
   input  logic        CDB_Valid,
   input  logic [5:0]  CDB_Tag,
   input  logic [31:0] CDB_Data,
   input  logic        Issue_Ready,
   output logic        Issue_Valid,
   output logic [3:0]  Issue_Opcode,
   output logic [4:0]  Issue_Shfamt,
   output logic [31:0] Issue_RsData,
   output logic [31:0] Issue_RtData,
   output logic [5:0]  Issue_RdTag
);

   localparam int DATA_W = 32;
   localparam int TAG_W  = 6;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   typedef struct packed {
      logic              vld;
      logic [3:0]        opcode;
      logic [4:0]        shfamt;
      logic              rs_rdy;
      logic [TAG_W-1:0]  rs_tag;
      logic [DATA_W-1:0] rs_data;
      logic              rt_rdy;
      logic [TAG_W-1:0]  rt_tag;
      logic [DATA_W-1:0] rt_data;
      logic [TAG_W-1:0]  rd_tag;
   } entry_t;

   entry_t           ent_q [DEPTH];
   entry_t           ent_d [DEPTH];
   entry_t           woken [DEPTH];
   entry_t           new_ent;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [CNT_W-1:0] cnt_after;
   logic [DEPTH-1:0] issue_oh;
   logic [DEPTH-1:0] shift;
   logic             do_issue;
   logic             do_disp;

   // Capture a matching broadcast into any waiting operand of a live entry.
   function automatic entry_t wake(input entry_t e, input logic cv,
                                   input logic [TAG_W-1:0] ct, input logic [DATA_W-1:0] cd);
      entry_t w;
      w = e;
      if (cv && e.vld) begin
         if (!e.rs_rdy && (e.rs_tag == ct)) begin
            w.rs_rdy  = 1'b1;
            w.rs_data = cd;
         end
         if (!e.rt_rdy && (e.rt_tag == ct)) begin
            w.rt_rdy  = 1'b1;
            w.rt_data = cd;
         end
      end
      return w;
   endfunction

   assign IssueQ_Full = (count_q == CNT_W'(DEPTH));
   assign do_disp     = Dispatch_en_Int && !IssueQ_Full;
   assign Issue_Valid = |issue_oh;
   assign do_issue    = Issue_Valid && Issue_Ready;
   assign cnt_after   = count_q - {{(CNT_W-1){1'b0}}, do_issue};

   always_comb begin
      logic found;
      found    = 1'b0;
      issue_oh = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!found && ent_q[i].vld && ent_q[i].rs_rdy && ent_q[i].rt_rdy) begin
            issue_oh[i] = 1'b1;
            found       = 1'b1;
         end
      end
   end

   // One-hot select drives everything to zero when nothing is issuable.
   always_comb begin
      Issue_Opcode = '0;
      Issue_Shfamt = '0;
      Issue_RsData = '0;
      Issue_RtData = '0;
      Issue_RdTag  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (issue_oh[i]) begin
            Issue_Opcode = ent_q[i].opcode;
            Issue_Shfamt = ent_q[i].shfamt;
            Issue_RsData = ent_q[i].rs_data;
            Issue_RtData = ent_q[i].rt_data;
            Issue_RdTag  = ent_q[i].rd_tag;
         end
      end
   end

   always_comb begin
      new_ent         = '0;
      new_ent.vld     = 1'b1;
      new_ent.opcode  = Dispatch_Opcode;
      new_ent.shfamt  = Dispatch_Shfamt;
      new_ent.rs_rdy  = Dispatch_RsRdy;
      new_ent.rs_tag  = Dispatch_RsTag;
      new_ent.rs_data = Dispatch_RsData;
      new_ent.rt_rdy  = Dispatch_Type_I | Dispatch_RtRdy;
      new_ent.rt_tag  = Dispatch_RtTag;
      new_ent.rt_data = Dispatch_Type_I ? Dispatch_Imm_LS : Dispatch_RtData;
      new_ent.rd_tag  = Dispatch_RdTag;
`ifdef ISSUEQ_CDB_BYPASS_EN
      if (CDB_Valid && !new_ent.rs_rdy && (Dispatch_RsTag == CDB_Tag)) begin
         new_ent.rs_rdy  = 1'b1;
         new_ent.rs_data = CDB_Data;
      end
      if (CDB_Valid && !new_ent.rt_rdy && (Dispatch_RtTag == CDB_Tag)) begin
         new_ent.rt_rdy  = 1'b1;
         new_ent.rt_data = CDB_Data;
      end
`endif
   end

   // Wake first, then compact, so an entry moving down still sees this cycle's broadcast.
   always_comb begin
      logic above;
      above = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         woken[i] = wake(ent_q[i], CDB_Valid, CDB_Tag, CDB_Data);
         above    = above | issue_oh[i];
         shift[i] = do_issue & above;
      end
      for (int i = 0; i < DEPTH - 1; i++) begin
         ent_d[i] = shift[i] ? woken[i+1] : woken[i];
      end
      ent_d[DEPTH-1] = shift[DEPTH-1] ? entry_t'('0) : woken[DEPTH-1];
      for (int i = 0; i < DEPTH; i++) begin
         if (do_disp && (cnt_after == CNT_W'(i))) begin
            ent_d[i] = new_ent;
         end
      end
      count_d = cnt_after + {{(CNT_W-1){1'b0}}, do_disp};
   end

   // Reset clears only occupancy and readiness; payload fields simply hold.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i].vld    <= 1'b0;
            ent_q[i].rs_rdy <= 1'b0;
            ent_q[i].rt_rdy <= 1'b0;
         end
      end else begin
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
         end
      end
   end

endmodule

// File: tb/tb_int_issue_queue.sv
// Directed bench for int_issue_queue with a scoreboard of expected issues and queued state checks.
module tb_int_issue_queue;

   logic        Clk;
   logic        Reset;
   logic        Dispatch_en_Int;
   logic [3:0]  Dispatch_Opcode;
   logic [4:0]  Dispatch_Shfamt;
   logic [31:0] Dispatch_Imm_LS;
   logic        Dispatch_Type_I;
   logic [5:0]  Dispatch_RsTag;
   logic [5:0]  Dispatch_RtTag;
   logic [31:0] Dispatch_RsData;
   logic [31:0] Dispatch_RtData;
   logic        Dispatch_RsRdy;
   logic        Dispatch_RtRdy;
   logic [5:0]  Dispatch_RdTag;
   logic        IssueQ_Full;
   logic        CDB_Valid;
   logic [5:0]  CDB_Tag;
   logic [31:0] CDB_Data;
   logic        Issue_Ready;
   logic        Issue_Valid;
   logic [3:0]  Issue_Opcode;
   logic [4:0]  Issue_Shfamt;
   logic [31:0] Issue_RsData;
   logic [31:0] Issue_RtData;
   logic [5:0]  Issue_RdTag;

   int_issue_queue #(.DEPTH(4)) dut (
      .Clk(Clk), .Reset(Reset),
      .Dispatch_en_Int(Dispatch_en_Int), .Dispatch_Opcode(Dispatch_Opcode),
      .Dispatch_Shfamt(Dispatch_Shfamt), .Dispatch_Imm_LS(Dispatch_Imm_LS),
      .Dispatch_Type_I(Dispatch_Type_I),
      .Dispatch_RsTag(Dispatch_RsTag), .Dispatch_RtTag(Dispatch_RtTag),
      .Dispatch_RsData(Dispatch_RsData), .Dispatch_RtData(Dispatch_RtData),
      .Dispatch_RsRdy(Dispatch_RsRdy), .Dispatch_RtRdy(Dispatch_RtRdy),
      .Dispatch_RdTag(Dispatch_RdTag), .IssueQ_Full(IssueQ_Full),
      .CDB_Valid(CDB_Valid), .CDB_Tag(CDB_Tag), .CDB_Data(CDB_Data),
      .Issue_Ready(Issue_Ready), .Issue_Valid(Issue_Valid),
      .Issue_Opcode(Issue_Opcode), .Issue_Shfamt(Issue_Shfamt),
      .Issue_RsData(Issue_RsData), .Issue_RtData(Issue_RtData),
      .Issue_RdTag(Issue_RdTag)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct packed {
      logic       full;
      logic       valid;
      logic       chk_rd;
      logic [5:0] rd;
      logic [7:0] id;
   } st_t;

   st_t         st_q [$];
   logic [78:0] sb_q [$];
   st_t         st_cur;
   logic [78:0] sb_cur;
   logic [78:0] got;
   int          n_cmp = 0;
   int          n_err = 0;
   logic        done = 1'b0;

   // Monitor: state checks and issue scoreboard, sampled on the falling edge.
   always @(negedge Clk) begin
      while (st_q.size() > 0) begin
         st_cur = st_q.pop_front();
         n_cmp++;
         if (IssueQ_Full !== st_cur.full) begin
            n_err++;
            $display("FAIL state%0d full: got %b want %b", st_cur.id, IssueQ_Full, st_cur.full);
         end
         n_cmp++;
         if (Issue_Valid !== st_cur.valid) begin
            n_err++;
            $display("FAIL state%0d valid: got %b want %b", st_cur.id, Issue_Valid, st_cur.valid);
         end
         if (st_cur.chk_rd) begin
            n_cmp++;
            if (Issue_RdTag !== st_cur.rd) begin
               n_err++;
               $display("FAIL state%0d rdtag: got %h want %h", st_cur.id, Issue_RdTag, st_cur.rd);
            end
         end
         if (!st_cur.valid) begin
            n_cmp++;
            got = {Issue_Opcode, Issue_Shfamt, Issue_RsData, Issue_RtData, Issue_RdTag};
            if (got !== '0) begin
               n_err++;
               $display("FAIL state%0d idle_data: got %h want 0", st_cur.id, got);
            end
         end
      end
      if (!Reset && Issue_Valid && Issue_Ready) begin
         n_cmp++;
         got = {Issue_Opcode, Issue_Shfamt, Issue_RsData, Issue_RtData, Issue_RdTag};
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_issue: got %h want none", got);
         end else begin
            sb_cur = sb_q.pop_front();
            if (got !== sb_cur) begin
               n_err++;
               $display("FAIL issue: got %h want %h", got, sb_cur);
            end
         end
      end
      if (done) begin
         n_cmp++;
         if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expected: got %0d pending want 0", sb_q.size());
         end
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
         $finish;
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish want finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
      Dispatch_en_Int = 1'b0;
      CDB_Valid       = 1'b0;
   endtask

   task automatic disp(input logic [3:0] op, input logic [4:0] shf, input logic ti,
                       input logic [31:0] imm, input logic [5:0] rst, input logic [31:0] rsd,
                       input logic rsr, input logic [5:0] rtt, input logic [31:0] rtd,
                       input logic rtr, input logic [5:0] rd);
      Dispatch_en_Int = 1'b1;
      Dispatch_Opcode = op;
      Dispatch_Shfamt = shf;
      Dispatch_Type_I = ti;
      Dispatch_Imm_LS = imm;
      Dispatch_RsTag  = rst;
      Dispatch_RsData = rsd;
      Dispatch_RsRdy  = rsr;
      Dispatch_RtTag  = rtt;
      Dispatch_RtData = rtd;
      Dispatch_RtRdy  = rtr;
      Dispatch_RdTag  = rd;
   endtask

   task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
      CDB_Valid = 1'b1;
      CDB_Tag   = tag;
      CDB_Data  = data;
   endtask

   task automatic exp_issue(input logic [3:0] op, input logic [4:0] shf, input logic [31:0] rs,
                            input logic [31:0] rt, input logic [5:0] rd);
      sb_q.push_back({op, shf, rs, rt, rd});
   endtask

   task automatic chk(input logic [7:0] id, input logic full, input logic valid,
                      input logic chk_rd, input logic [5:0] rd);
      st_q.push_back('{full: full, valid: valid, chk_rd: chk_rd, rd: rd, id: id});
   endtask

   initial begin
      Reset = 1'b1;
      Dispatch_en_Int = 1'b0; Dispatch_Opcode = '0; Dispatch_Shfamt = '0;
      Dispatch_Imm_LS = '0; Dispatch_Type_I = 1'b0; Dispatch_RsTag = '0;
      Dispatch_RtTag = '0; Dispatch_RsData = '0; Dispatch_RtData = '0;
      Dispatch_RsRdy = 1'b0; Dispatch_RtRdy = 1'b0; Dispatch_RdTag = '0;
      CDB_Valid = 1'b0; CDB_Tag = '0; CDB_Data = '0; Issue_Ready = 1'b0;
      tick();
      tick();
      Reset = 1'b0;
      chk(1, 1'b0, 1'b0, 1'b0, 6'd0);
      tick();

      // ADD with both operands ready issues the cycle after dispatch.
      Issue_Ready = 1'b1;
      disp(4'd2, 5'd0, 1'b0, 32'd0, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7, 1'b1, 6'd1);
      exp_issue(4'd2, 5'd0, 32'd5, 32'd7, 6'd1);
      tick();
      tick();
      chk(2, 1'b0, 1'b0, 1'b0, 6'd0);

      // Fill to full; the last entry is I-type so its rt comes from the immediate.
      Issue_Ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         disp(4'(i + 1), 5'(i), (i == 3), 32'h1234, 6'd0, 32'(32'h100 + i), 1'b1,
              6'd0, 32'(32'h200 + i), 1'b1, 6'(16 + i));
         exp_issue(4'(i + 1), 5'(i), 32'(32'h100 + i), (i == 3) ? 32'h1234 : 32'(32'h200 + i),
                   6'(16 + i));
         tick();
      end
      chk(3, 1'b1, 1'b1, 1'b1, 6'd16);
      disp(4'd9, 5'd0, 1'b0, 32'd0, 6'd0, 32'h999, 1'b1, 6'd0, 32'h998, 1'b1, 6'd31);
      tick();
      chk(4, 1'b1, 1'b1, 1'b1, 6'd16);
      Issue_Ready = 1'b1;
      tick();
      Issue_Ready = 1'b0;
      chk(5, 1'b0, 1'b1, 1'b1, 6'd17);
      Issue_Ready = 1'b1;
      tick();
      tick();
      tick();
      chk(6, 1'b0, 1'b0, 1'b0, 6'd0);

      // Rs waits on tag 0x12; a non-matching broadcast must not wake it.
      disp(4'd5, 5'd3, 1'b0, 32'd0, 6'h12, 32'd0, 1'b0, 6'd0, 32'h11, 1'b1, 6'd3);
      tick();
      chk(7, 1'b0, 1'b0, 1'b0, 6'd0);
      cdb(6'h13, 32'hFFFF);
      tick();
      chk(8, 1'b0, 1'b0, 1'b0, 6'd0);
      cdb(6'h12, 32'hCAFE);
      exp_issue(4'd5, 5'd3, 32'hCAFE, 32'h11, 6'd3);
      tick();
      tick();
      chk(9, 1'b0, 1'b0, 1'b0, 6'd0);

      // Younger ready entry overtakes an older waiting one.
      Issue_Ready = 1'b0;
      disp(4'd6, 5'd0, 1'b0, 32'd0, 6'h20, 32'd0, 1'b0, 6'd0, 32'h22, 1'b1, 6'd4);
      tick();
      disp(4'd7, 5'd1, 1'b0, 32'd0, 6'd0, 32'h70, 1'b1, 6'd0, 32'h71, 1'b1, 6'd5);
      exp_issue(4'd7, 5'd1, 32'h70, 32'h71, 6'd5);
      tick();
      chk(10, 1'b0, 1'b1, 1'b1, 6'd5);
      Issue_Ready = 1'b1;
      tick();
      Issue_Ready = 1'b0;
      chk(11, 1'b0, 1'b0, 1'b0, 6'd0);
      cdb(6'h20, 32'hBEEF);
      exp_issue(4'd6, 5'd0, 32'hBEEF, 32'h22, 6'd4);
      tick();
      chk(12, 1'b0, 1'b1, 1'b1, 6'd4);
      Issue_Ready = 1'b1;
      tick();
      chk(13, 1'b0, 1'b0, 1'b0, 6'd0);

      // Broadcast lands on an entry while it shifts down.
      Issue_Ready = 1'b0;
      disp(4'd8, 5'd2, 1'b0, 32'd0, 6'd0, 32'h80, 1'b1, 6'd0, 32'h81, 1'b1, 6'd6);
      exp_issue(4'd8, 5'd2, 32'h80, 32'h81, 6'd6);
      tick();
      disp(4'd9, 5'd0, 1'b0, 32'd0, 6'd0, 32'h91, 1'b1, 6'h2A, 32'd0, 1'b0, 6'd7);
      tick();
      Issue_Ready = 1'b1;
      cdb(6'h2A, 32'h5151);
      exp_issue(4'd9, 5'd0, 32'h91, 32'h5151, 6'd7);
      tick();
      tick();
      chk(14, 1'b0, 1'b0, 1'b0, 6'd0);

      // Dispatch and issue in the same cycle.
      Issue_Ready = 1'b0;
      disp(4'd10, 5'd0, 1'b0, 32'd0, 6'd0, 32'hA0, 1'b1, 6'd0, 32'hA1, 1'b1, 6'd8);
      exp_issue(4'd10, 5'd0, 32'hA0, 32'hA1, 6'd8);
      tick();
      Issue_Ready = 1'b1;
      disp(4'd11, 5'd31, 1'b0, 32'd0, 6'd0, 32'hB0, 1'b1, 6'd0, 32'hB1, 1'b1, 6'd9);
      exp_issue(4'd11, 5'd31, 32'hB0, 32'hB1, 6'd9);
      tick();
      tick();
      chk(15, 1'b0, 1'b0, 1'b0, 6'd0);

      // Same-cycle CDB match at dispatch.
      disp(4'd3, 5'd0, 1'b0, 32'd0, 6'h03, 32'd0, 1'b0, 6'd0, 32'h33, 1'b1, 6'd10);
      cdb(6'h03, 32'h7777);
`ifdef ISSUEQ_CDB_BYPASS_EN
      exp_issue(4'd3, 5'd0, 32'h7777, 32'h33, 6'd10);
      tick();
      tick();
      chk(16, 1'b0, 1'b0, 1'b0, 6'd0);
`else
      tick();
      chk(16, 1'b0, 1'b0, 1'b0, 6'd0);
      cdb(6'h03, 32'h8888);
      exp_issue(4'd3, 5'd0, 32'h8888, 32'h33, 6'd10);
      tick();
      tick();
      chk(17, 1'b0, 1'b0, 1'b0, 6'd0);
`endif

      // Reset wins over a pending entry and a same-edge dispatch.
      Issue_Ready = 1'b0;
      disp(4'd12, 5'd0, 1'b0, 32'd0, 6'd0, 32'hC0, 1'b1, 6'd0, 32'hC1, 1'b1, 6'd11);
      tick();
      Reset = 1'b1;
      disp(4'd13, 5'd0, 1'b0, 32'd0, 6'd0, 32'hD0, 1'b1, 6'd0, 32'hD1, 1'b1, 6'd12);
      tick();
      Reset = 1'b0;
      chk(18, 1'b0, 1'b0, 1'b0, 6'd0);
      Issue_Ready = 1'b1;
      tick();
      tick();
      chk(19, 1'b0, 1'b0, 1'b0, 6'd0);
      tick();
      done = 1'b1;
   end

endmodule
